// File: rtl/cnn_pkg.sv
// Shared CNN constants and the weight-loader state encoding, reused by the buffer and read-side control.
package cnn_pkg;

  localparam int CNN_DATA_W = 8;
  localparam int CNN_TAPS   = 9;
  localparam int CNN_DEPTH  = 21;
  localparam int CNN_IDX_W  = 7;

  function automatic int wl_word_w(input int data_w, input int taps);
    return data_w * taps;
  endfunction

  localparam int CNN_WORD_W = wl_word_w(CNN_DATA_W, CNN_TAPS);

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_LOAD  = 2'd1,
    WL_FLUSH = 2'd2,
    WL_DONE  = 2'd3
  } wl_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// Byte-stream input and weight-buffer write port of the weight loader.
interface weight_loader_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int IDX_W  = CNN_IDX_W,
  parameter int WORD_W = CNN_WORD_W
) ();

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wb_wen;
  logic [IDX_W-1:0]  wb_index;
  logic [WORD_W-1:0] wb_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wb_wen, wb_index, wb_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wb_wen, wb_index, wb_data
  );

endinterface

// File: rtl/wl_packer.sv
// Packs TAPS accepted bytes into one word, first byte in the top lane; word_valid pulses one
// cycle after the last byte of a word is accepted and word holds until the next word completes.
module wl_packer
  import cnn_pkg::*;
#(
  parameter  int DATA_W = CNN_DATA_W,
  parameter  int TAPS   = CNN_TAPS,
  localparam int WORD_W = DATA_W * TAPS,
  localparam int CNT_W  = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic [WORD_W-DATA_W-1:0] shift_q, shift_d;
  logic                     word_valid_q, word_valid_d;
  logic [WORD_W-1:0]        word_q, word_d;

  assign last_byte = in_valid && (byte_cnt_q == CNT_W'(TAPS - 1));

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      byte_cnt_d = '0;
    end else if (in_valid) begin
      if (last_byte) begin
        // Earlier bytes have shifted upward, so byte 0 lands in the top lane.
        word_d       = {shift_q, in_data};
        word_valid_d = 1'b1;
        byte_cnt_d   = '0;
      end else begin
        shift_d    = {shift_q[WORD_W-2*DATA_W-1:0], in_data};
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/weight_loader.sv
// Weight buffer write-side feeder: one load of up to DEPTH kernels per start pulse.
// Optional build macro WLOAD_CHECKSUM_EN adds a 16-bit sum of accepted bytes on port checksum.
module weight_loader
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int TAPS   = CNN_TAPS,
  parameter int DEPTH  = CNN_DEPTH,
  parameter int IDX_W  = CNN_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_kernels,
  weight_loader_if.slave   bus,
  output logic             busy,
  output logic             done
`ifdef WLOAD_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int WORD_W = wl_word_w(DATA_W, TAPS);

  wl_state_t         state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  kern_cnt_q, kern_cnt_d;
  logic [IDX_W-1:0]  wb_index_q, wb_index_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs;
  logic              load_clear;
  logic              last_byte;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  n_start;

  assign hs         = bus.s_valid && s_ready_q;
  assign load_clear = (state_q == WL_IDLE) && start;
  assign n_start    = (num_kernels > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : num_kernels;

  wl_packer #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_clear),
    .in_valid   (hs),
    .in_data    (bus.s_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    kern_cnt_d = kern_cnt_q;
    wb_index_d = wb_index_q;
    unique case (state_q)
      WL_IDLE: begin
        if (start) begin
          n_d        = n_start;
          kern_cnt_d = '0;
          state_d    = (n_start == '0) ? WL_DONE : WL_LOAD;
        end
      end
      WL_LOAD: begin
        if (last_byte) begin
          wb_index_d = kern_cnt_q;
          kern_cnt_d = kern_cnt_q + IDX_W'(1);
          if (kern_cnt_q == n_q - IDX_W'(1)) begin
            state_d = WL_FLUSH;
          end
        end
      end
      WL_FLUSH: state_d = WL_DONE;
      WL_DONE:  state_d = WL_IDLE;
      default:  state_d = WL_IDLE;
    endcase
    // Status outputs follow the next state so they are registered yet line up with it.
    s_ready_d = (state_d == WL_LOAD);
    busy_d    = (state_d == WL_LOAD) || (state_d == WL_FLUSH);
    done_d    = (state_d == WL_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WL_IDLE;
      n_q        <= '0;
      kern_cnt_q <= '0;
      wb_index_q <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      kern_cnt_q <= kern_cnt_d;
      wb_index_q <= wb_index_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_clear) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q + 16'(bus.s_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign bus.s_ready  = s_ready_q;
  assign bus.wb_wen   = word_valid;
  assign bus.wb_index = wb_index_q;
  assign bus.wb_data  = word;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
